// File: rtl/mm_pkg.sv
// Shared definitions for the matrix multiplier and its result reader.
package mm_pkg;

  // Readout / multiply sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO used as the skid buffer in front of the output stream.
// The head entry is presented combinationally on dout; a push and pop in the
// same cycle leave the count unchanged and preserve order.
module stream_fifo2 #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (cnt_r == 2'd0);
  assign full      = (cnt_r == 2'd2);
  assign cnt       = cnt_r;
  assign dout      = mem_r[rd_ptr_r];
  // A pop frees the head slot, so a push into a full FIFO is safe in that cycle.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/matrix_result_reader.sv
// Reads the Z_ROWS x Z_COLS result matrix out of the result RAM in row-major
// order and streams it on a valid/ready interface with row and matrix markers.
// Reads are credit-limited so that at most two elements are ever held between
// the RAM read port and the output (one in flight plus FIFO contents).
module matrix_result_reader
  import mm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int Z_ROWS     = 5,
  parameter int Z_COLS     = 5,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  z_rd_en,
  output logic [ADDR_WIDTH-1:0] z_rd_addr,
  input  logic [DATA_WIDTH-1:0] z_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_row_last,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int N     = Z_ROWS * Z_COLS;
  localparam int IDX_W = $clog2(N + 1);
  localparam int COL_W = (Z_COLS > 1) ? $clog2(Z_COLS) : 1;
  localparam int FW    = DATA_WIDTH + 2;

  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(Z_COLS - 1);

  state_t                state_r;
  logic [IDX_W-1:0]      rd_idx_r;
  logic [COL_W-1:0]      rd_col_r;
  logic [IDX_W-1:0]      out_idx_r;
  logic [COL_W-1:0]      out_col_r;
  logic                  inflight_r;
  logic [1:0]            inflight_flags_r;
  logic [ADDR_WIDTH-1:0] last_addr_r;

  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic [2:0]            credit_s;
  logic [ADDR_WIDTH-1:0] issue_addr_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [1:0]            fifo_cnt_s;
  logic [FW-1:0]         fifo_dout_s;

  // Elements already claimed downstream of the read port once this cycle's pop retires.
  assign credit_s     = {1'b0, fifo_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s      = (state_r == READ) && (rd_idx_r < N_IDX) && (credit_s < 3'd2);
  assign issue_addr_s = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_idx_r);

  assign pop_s        = m_valid & m_ready;
  assign push_s       = inflight_r & (~fifo_full_s | pop_s);

  assign z_rd_en      = issue_s;
  assign m_valid      = ~fifo_empty_s;
  assign m_row_last   = fifo_dout_s[FW-1];
  assign m_last       = fifo_dout_s[FW-2];
  assign m_data       = fifo_dout_s[DATA_WIDTH-1:0];
  assign busy         = (state_r != IDLE);
  assign done         = (state_r == DRAIN) && pop_s &&
                        (out_idx_r == LAST_IDX) && (out_col_r == LAST_COL);

  // Address output follows rd_idx while issuing and otherwise holds the last address used.
  always_comb begin
    z_rd_addr = last_addr_r;
    if (issue_s) begin
      z_rd_addr = issue_addr_s;
    end else begin
      z_rd_addr = last_addr_r;
    end
  end

  // Readout sequencer with its read-side and output-side position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rd_idx_r    <= '0;
      rd_col_r    <= '0;
      out_idx_r   <= '0;
      out_col_r   <= '0;
      last_addr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= READ;
            rd_idx_r  <= '0;
            rd_col_r  <= '0;
            out_idx_r <= '0;
            out_col_r <= '0;
          end
        end
        READ: begin
          if (rd_idx_r == N_IDX) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (issue_s) begin
        rd_idx_r    <= rd_idx_r + IDX_W'(1);
        rd_col_r    <= (rd_col_r == LAST_COL) ? '0 : rd_col_r + COL_W'(1);
        last_addr_r <= issue_addr_s;
      end

      if (pop_s) begin
        out_idx_r <= out_idx_r + IDX_W'(1);
        out_col_r <= (out_col_r == LAST_COL) ? '0 : out_col_r + COL_W'(1);
      end
    end
  end

  // Track the read in flight together with the markers that belong to its element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r       <= 1'b0;
      inflight_flags_r <= 2'b00;
    end else begin
      inflight_r       <= issue_s;
      inflight_flags_r <= {(rd_col_r == LAST_COL), (rd_idx_r == LAST_IDX)};
    end
  end

  stream_fifo2 #(
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   ({inflight_flags_r, z_rd_data}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .cnt   (fifo_cnt_s)
  );

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed bench for matrix_result_reader: a 5x5 instance at base 0 and a
// 1x3 instance at base 16, each fed by a one-cycle-latency RAM model whose
// content is value[a] = a + 100. Expected elements are queued at start.
module tb_matrix_result_reader;

  typedef struct {
    logic [31:0] data;
    logic        rl;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_v;
  logic [1:0]  m_ready_v;
  wire  [1:0]  z_rd_en_v;
  wire  [1:0]  m_valid_v;
  wire  [1:0]  m_row_last_v;
  wire  [1:0]  m_last_v;
  wire  [1:0]  busy_v;
  wire  [1:0]  done_v;
  wire  [31:0] z_rd_addr_v [2];
  wire  [31:0] m_data_v [2];
  logic [31:0] ram_q [2];

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // RAM models: one cycle read latency, value = address + 100.
  always @(posedge clk) begin
    if (z_rd_en_v[0]) ram_q[0] <= z_rd_addr_v[0] + 32'd100;
    if (z_rd_en_v[1]) ram_q[1] <= z_rd_addr_v[1] + 32'd100;
  end

  matrix_result_reader #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .Z_ROWS (5), .Z_COLS (5), .BASE_ADDR (0)
  ) dut_a (
    .clk (clk), .rst (rst), .start (start_v[0]),
    .z_rd_en (z_rd_en_v[0]), .z_rd_addr (z_rd_addr_v[0]), .z_rd_data (ram_q[0]),
    .m_valid (m_valid_v[0]), .m_ready (m_ready_v[0]), .m_data (m_data_v[0]),
    .m_row_last (m_row_last_v[0]), .m_last (m_last_v[0]),
    .busy (busy_v[0]), .done (done_v[0])
  );

  matrix_result_reader #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .Z_ROWS (1), .Z_COLS (3), .BASE_ADDR (16)
  ) dut_b (
    .clk (clk), .rst (rst), .start (start_v[1]),
    .z_rd_en (z_rd_en_v[1]), .z_rd_addr (z_rd_addr_v[1]), .z_rd_data (ram_q[1]),
    .m_valid (m_valid_v[1]), .m_ready (m_ready_v[1]), .m_data (m_data_v[1]),
    .m_row_last (m_row_last_v[1]), .m_last (m_last_v[1]),
    .busy (busy_v[1]), .done (done_v[1])
  );

  function automatic int rows_of(input int sel);
    return (sel == 0) ? 5 : 1;
  endfunction

  function automatic int cols_of(input int sel);
    return (sel == 0) ? 5 : 3;
  endfunction

  function automatic int base_of(input int sel);
    return (sel == 0) ? 0 : 16;
  endfunction

  // mode 0: always ready; mode 1: repeating 1,0,0,1 starting at cycle T+1.
  function automatic logic ready_for(input int mode, input int k);
    int p;
    p = (k - 1) % 4;
    if (mode == 0) return 1'b1;
    return (p == 0) || (p == 3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    chk({tag, "_rd_en"},    z_rd_en_v[sel],    0);
    chk({tag, "_rd_addr"},  z_rd_addr_v[sel],  0);
    chk({tag, "_valid"},    m_valid_v[sel],    0);
    chk({tag, "_data"},     m_data_v[sel],     0);
    chk({tag, "_row_last"}, m_row_last_v[sel], 0);
    chk({tag, "_last"},     m_last_v[sel],     0);
    chk({tag, "_busy"},     busy_v[sel],       0);
    chk({tag, "_done"},     done_v[sel],       0);
  endtask

  task automatic run_readout(input int sel, input int mode, input int restart_k, input int abort_hs);
    int          n, cols, base, k, hs, issued, dones, max_out, outs;
    int          first_en, first_valid, done_k;
    bit          stalled, hs_now;
    logic [33:0] held;
    exp_t        e;

    cols = cols_of(sel);
    n    = rows_of(sel) * cols;
    base = base_of(sel);
    k = 0; hs = 0; issued = 0; dones = 0; max_out = 0;
    first_en = -1; first_valid = -1; done_k = -1;
    stalled = 1'b0; held = '0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.data = 32'(base + i + 100);
      e.rl   = ((i % cols) == cols - 1);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end

    // Cycle T: start is high and sampled at the closing edge.
    @(posedge clk); #1;
    start_v[sel]   = 1'b1;
    m_ready_v[sel] = 1'b1;

    while ((k < 200) && ((done_k < 0) || (k < done_k + 4))) begin
      @(posedge clk); #1;
      k++;
      start_v[sel]   = (k == restart_k);
      m_ready_v[sel] = ready_for(mode, k);
      if ((abort_hs > 0) && (hs == abort_hs)) begin
        rst = 1'b1;
        #1;
        check_idle(sel, "abort");
        exp_q.delete();
        start_v[sel]   = 1'b0;
        m_ready_v[sel] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", m_valid_v[sel], 1);
        chk("stall_hold", {m_row_last_v[sel], m_last_v[sel], m_data_v[sel]}, held);
      end
      if (m_valid_v[sel] && (first_valid < 0)) first_valid = k;
      if (z_rd_en_v[sel]) begin
        if (first_en < 0) first_en = k;
        chk("rd_addr", z_rd_addr_v[sel], base + issued);
        issued++;
      end
      chk("busy", busy_v[sel], (done_k < 0));
      hs_now = m_valid_v[sel] && m_ready_v[sel];
      if (hs_now) begin
        if (exp_q.size() == 0) begin
          chk("extra_element", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data_v[sel], e.data);
          chk("m_row_last", m_row_last_v[sel], e.rl);
          chk("m_last", m_last_v[sel], e.last);
        end
        hs++;
      end
      chk("done", done_v[sel], hs_now && (hs == n));
      if (done_v[sel]) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      outs = issued - hs;
      if (outs > max_out) max_out = outs;
      stalled = m_valid_v[sel] && !m_ready_v[sel];
      held    = {m_row_last_v[sel], m_last_v[sel], m_data_v[sel]};
    end
    start_v[sel] = 1'b0;

    chk("finished_in_budget", (done_k >= 0), 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("element_count", hs, n);
    chk("read_count", issued, n);
    chk("done_pulses", dones, 1);
    chk("outstanding_le_2", (max_out <= 2), 1);
    chk("first_rd_en_cycle", first_en, 1);
    chk("first_valid_cycle", first_valid, 3);
    if (mode == 0) chk("done_cycle", done_k, n + 2);
  endtask

  initial begin
    rst       = 1'b1;
    start_v   = 2'b00;
    m_ready_v = 2'b11;

    // Reset held for 3 cycles, then 20 idle cycles without start.
    repeat (3) begin
      @(negedge clk);
      check_idle(0, "in_reset_a");
      check_idle(1, "in_reset_b");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check_idle(0, "idle_a");
      check_idle(1, "idle_b");
    end

    // Full throughput 5x5.
    run_readout(0, 0, 0, 0);
    // Backpressure 1,0,0,1.
    run_readout(0, 1, 0, 0);
    // Second start in cycle T+5 is ignored.
    run_readout(0, 0, 5, 0);
    // Reset after the 7th handshake, then a fresh readout from value 100.
    run_readout(0, 0, 0, 7);
    run_readout(0, 0, 0, 0);
    // 1x3 geometry at base address 16.
    run_readout(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
